bus_timer: RTL and testbench

Memory-mapped machine timer that acts as a responder on the core's data-side req/gnt/rvalid bus, so it is the other end of the core's load/store interface. It holds a 64-bit `mtime` counter with a programmable prescaler, a 64-bit `mtimecmp` compare register and a control register. It drives a level timer interrupt into the core's `irq_timer_i`. It sits beside the single-port SRAM on the data bus, behind an external address decoder that asserts `req_i` only for this block's 4 KiB window.

---
 rtl/bus_timer_pkg.sv | 70 +++++++
 rtl/timer_prescaler.sv | 28 ++
 rtl/bus_timer.sv | 125 ++++++++++++
 tb/tb_bus_timer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
// Shared constants, register decode and bus payload types for the memory-mapped machine timer.
package bus_timer_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BE_W       = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned PRESCALE_W = 16;
    localparam int unsigned MTIME_W    = 64;
    localparam int unsigned OFFSET_W   = 12;
    localparam int unsigned WORD_IDX_W = 10;

    localparam logic [OFFSET_W-1:0] CTRL_OFFSET        = 12'h000;
    localparam logic [OFFSET_W-1:0] PRESCALE_OFFSET    = 12'h004;
    localparam logic [OFFSET_W-1:0] MTIME_LO_OFFSET    = 12'h008;
    localparam logic [OFFSET_W-1:0] MTIME_HI_OFFSET    = 12'h00C;
    localparam logic [OFFSET_W-1:0] MTIMECMP_LO_OFFSET = 12'h010;
    localparam logic [OFFSET_W-1:0] MTIMECMP_HI_OFFSET = 12'h014;

    localparam int unsigned CTRL_EN_BIT = 0;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_PRESCALE,
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_MTIMECMP_LO,
        REG_MTIMECMP_HI,
        REG_NONE
    } reg_idx_e;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } bus_rsp_t;

    // Map a word address (addr[11:2]) onto a register index; unmapped offsets give REG_NONE.
    function automatic reg_idx_e decode_reg(input logic [WORD_IDX_W-1:0] word_addr);
        logic [OFFSET_W-1:0] off;
        reg_idx_e            idx;
        off = {word_addr, 2'b00};
        case (off)
            CTRL_OFFSET:        idx = REG_CTRL;
            PRESCALE_OFFSET:    idx = REG_PRESCALE;
            MTIME_LO_OFFSET:    idx = REG_MTIME_LO;
            MTIME_HI_OFFSET:    idx = REG_MTIME_HI;
            MTIMECMP_LO_OFFSET: idx = REG_MTIMECMP_LO;
            MTIMECMP_HI_OFFSET: idx = REG_MTIMECMP_HI;
            default:            idx = REG_NONE;
        endcase
        return idx;
    endfunction

    // Byte-lane merge of a write into an existing 32-bit word.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the system clock by PRESCALE+1 and emits a one-cycle tick while enabled.
module timer_prescaler
    import bus_timer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pcnt;

    assign tick_o = en_i && (pcnt == prescale_i);

    // Counter parks at zero while disabled so enabling starts a full period.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt <= '0;
        end else if (!en_i || clr_i || tick_o) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Machine timer responder on the data-side req/gnt/rvalid bus: mtime, mtimecmp, prescaler and level irq.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [PRESCALE_W-1:0] PrescaleReset = 16'd0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              irq_timer_o
);

    reg_idx_e              req_idx_c;
    logic                  hit_c;
    logic                  wr_c;
    logic                  tick;
    logic [DATA_W-1:0]     rd_mux_c;
    logic [MTIME_W-1:0]    mtime_nxt_c;
    logic [MTIME_W-1:0]    mtimecmp_nxt_c;

    logic                  ctrl_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [MTIME_W-1:0]    mtime;
    logic [MTIME_W-1:0]    mtimecmp;
    logic                  irq_q;
    bus_rsp_t              rsp_q;

    logic                  unused_addr;
    assign unused_addr = ^{addr_i[ADDR_W-1:OFFSET_W], addr_i[1:0]};

    assign gnt_o       = req_i;
    assign rvalid_o    = rsp_q.valid;
    assign err_o       = rsp_q.err;
    assign rdata_o     = rsp_q.data;
    assign irq_timer_o = irq_q;

    assign req_idx_c = decode_reg(addr_i[OFFSET_W-1:2]);
    assign hit_c     = req_i && (req_idx_c != REG_NONE);
    assign wr_c      = hit_c && we_i;

    timer_prescaler u_prescaler (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (ctrl_en),
        .clr_i      (wr_c && (req_idx_c == REG_PRESCALE)),
        .prescale_i (prescale),
        .tick_o     (tick)
    );

    // Read mux sees register state before any same-cycle write or tick.
    always_comb begin
        rd_mux_c = '0;
        case (req_idx_c)
            REG_CTRL:        rd_mux_c[CTRL_EN_BIT] = ctrl_en;
            REG_PRESCALE:    rd_mux_c[PRESCALE_W-1:0] = prescale;
            REG_MTIME_LO:    rd_mux_c = mtime[31:0];
            REG_MTIME_HI:    rd_mux_c = mtime[63:32];
            REG_MTIMECMP_LO: rd_mux_c = mtimecmp[31:0];
            REG_MTIMECMP_HI: rd_mux_c = mtimecmp[63:32];
            default:         rd_mux_c = '0;
        endcase
    end

    // A bus write to either mtime half wins over the tick for that cycle.
    always_comb begin
        mtime_nxt_c = mtime;
        if (wr_c && (req_idx_c == REG_MTIME_LO)) begin
            mtime_nxt_c[31:0] = merge_bytes(mtime[31:0], wdata_i, be_i);
        end else if (wr_c && (req_idx_c == REG_MTIME_HI)) begin
            mtime_nxt_c[63:32] = merge_bytes(mtime[63:32], wdata_i, be_i);
        end else if (tick) begin
            mtime_nxt_c = mtime + MTIME_W'(1);
        end
    end

    always_comb begin
        mtimecmp_nxt_c = mtimecmp;
        if (wr_c && (req_idx_c == REG_MTIMECMP_LO)) begin
            mtimecmp_nxt_c[31:0] = merge_bytes(mtimecmp[31:0], wdata_i, be_i);
        end else if (wr_c && (req_idx_c == REG_MTIMECMP_HI)) begin
            mtimecmp_nxt_c[63:32] = merge_bytes(mtimecmp[63:32], wdata_i, be_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_en  <= 1'b0;
            prescale <= PrescaleReset;
            mtime    <= '0;
            mtimecmp <= '1;
        end else begin
            if (wr_c && (req_idx_c == REG_CTRL) && be_i[CTRL_EN_BIT / 8]) begin
                ctrl_en <= wdata_i[CTRL_EN_BIT];
            end
            if (wr_c && (req_idx_c == REG_PRESCALE)) begin
                if (be_i[0]) prescale[7:0]  <= wdata_i[7:0];
                if (be_i[1]) prescale[15:8] <= wdata_i[15:8];
            end
            mtime    <= mtime_nxt_c;
            mtimecmp <= mtimecmp_nxt_c;
        end
    end

    // Interrupt level and single-cycle bus response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
            rsp_q <= '0;
        end else begin
            irq_q      <= ctrl_en && (mtime >= mtimecmp);
            rsp_q.valid <= req_i;
            rsp_q.err   <= req_i && (req_idx_c == REG_NONE);
            rsp_q.data  <= (hit_c && !we_i) ? rd_mux_c : '0;
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: reset/register table, hand-written timing corners, then random traffic vs a reference model.
module tb_bus_timer;
    import bus_timer_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        irq_timer_o;

    always #5 clk_i = ~clk_i;

    bus_timer #(.PrescaleReset(16'd0)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .irq_timer_o (irq_timer_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural registers plus a count of enabled cycles since the last tick.
    logic        m_en;
    logic [15:0] m_pre;
    int unsigned m_since;
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        e_rvalid, e_err, e_irq;
    logic [31:0] e_rdata;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 1'b0; m_pre = 16'd0; m_since = 0; m_mtime = 64'd0; m_cmp = '1;
        e_rvalid = 1'b0; e_err = 1'b0; e_irq = 1'b0; e_rdata = 32'd0;
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        case (idx)
            0: return {31'd0, m_en};
            1: return {16'd0, m_pre};
            2: return m_mtime[31:0];
            3: return m_mtime[63:32];
            4: return m_cmp[31:0];
            5: return m_cmp[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic req, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
        int          idx;
        bit          ok, tick, wr;
        logic [31:0] tmp;
        idx      = int'(addr[11:2]);
        ok       = (idx <= 5);
        e_rvalid = req;
        e_err    = req && !ok;
        e_rdata  = (req && !we && ok) ? m_read(idx) : 32'd0;
        e_irq    = m_en && (m_mtime >= m_cmp);
        tick     = m_en && (m_since == int'(m_pre));
        m_since  = (!m_en || tick) ? 0 : m_since + 1;
        wr       = req && we && ok;
        if (tick && !(wr && (idx == 2 || idx == 3))) m_mtime = m_mtime + 64'd1;
        if (wr) begin
            case (idx)
                0: if (be[0]) m_en = wdata[0];
                1: begin tmp = bmerge({16'd0, m_pre}, wdata, be); m_pre = tmp[15:0]; m_since = 0; end
                2: m_mtime[31:0]  = bmerge(m_mtime[31:0], wdata, be);
                3: m_mtime[63:32] = bmerge(m_mtime[63:32], wdata, be);
                4: m_cmp[31:0]    = bmerge(m_cmp[31:0], wdata, be);
                5: m_cmp[63:32]   = bmerge(m_cmp[63:32], wdata, be);
                default: ;
            endcase
        end
    endtask

    // One bus cycle starting and ending at a falling edge; all outputs checked against the model.
    task automatic cycle(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_i = req; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
        #1 check("gnt", gnt_o, req);
        @(posedge clk_i);
        model_step(req, we, be, addr, wdata);
        @(negedge clk_i);
        check("rvalid", rvalid_o, e_rvalid);
        if (e_rvalid) begin
            check("rdata", rdata_o, e_rdata);
            check("err", err_o, e_err);
        end
        check("irq", irq_timer_o, e_irq);
        last_rdata = rdata_o;
        last_err   = err_o;
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] d);
        cycle(1'b1, 1'b1, 4'hF, {20'd0, off}, d);
    endtask
    task automatic rd(input logic [11:0] off);
        cycle(1'b1, 1'b0, 4'h0, {20'd0, off}, 32'd0);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [11:0] off;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        logic [31:0] a;
        int idx;
        logic [31:0] d;

        vecs[0]  = '{1'b0, 4'h0, 12'h000, 32'h0,        32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 12'h004, 32'h0,        32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 4'h0, 12'h008, 32'h0,        32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 4'h0, 12'h00C, 32'h0,        32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 12'h010, 32'h0,        32'hFFFF_FFFF, 1'b0};
        vecs[5]  = '{1'b0, 4'h0, 12'h014, 32'h0,        32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{1'b1, 4'h2, 12'h010, 32'h0000_AB00, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b0, 4'h0, 12'h010, 32'h0,        32'hFFFF_ABFF, 1'b0};
        vecs[8]  = '{1'b0, 4'h0, 12'h020, 32'h0,        32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 4'hF, 12'h020, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 4'h0, 12'h010, 32'h0,        32'hFFFF_ABFF, 1'b0};
        vecs[11] = '{1'b0, 4'h0, 12'h000, 32'h0,        32'h0000_0000, 1'b0};
        vecs[12] = '{1'b1, 4'hF, 12'h000, 32'hFFFF_FFFE, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 4'h0, 12'h000, 32'h0,        32'h0000_0000, 1'b0};
        vecs[14] = '{1'b1, 4'hC, 12'h004, 32'hFFFF_0000, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b0, 4'h0, 12'h004, 32'h0,        32'h0000_0000, 1'b0};

        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 32'd0; wdata_i = 32'd0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        check("reset_rvalid", rvalid_o, 1'b0);
        check("reset_rdata", rdata_o, 32'd0);
        check("reset_err", err_o, 1'b0);
        check("reset_irq", irq_timer_o, 1'b0);
        rst_i = 1'b0;

        // Register table: reset values, byte write, unmapped offset, read-as-zero fields.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, vecs[i].we, vecs[i].be, {20'd0, vecs[i].off}, vecs[i].wdata);
            check($sformatf("vec%0d_rdata", i), last_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), last_err, vecs[i].exp_err);
        end
        wr(12'h010, 32'hFFFF_FFFF);

        // Prescale 3: ten ticks in the 40 cycles after enabling.
        wr(12'h004, 32'd3);
        wr(12'h000, 32'd1);
        idle(40);
        rd(12'h008);
        checks++;
        if (last_rdata < 32'd10 || last_rdata > 32'd11) begin
            failures++;
            $display("FAIL prescale_count: got %0d want 10..11", last_rdata);
        end
        check("prescale_irq", irq_timer_o, 1'b0);

        // Interrupt rises one cycle after mtime reaches 5, drops one cycle after mtimecmp is raised.
        wr(12'h000, 32'd0);
        wr(12'h004, 32'd0);
        wr(12'h008, 32'd0);
        wr(12'h00C, 32'd0);
        wr(12'h014, 32'd0);
        wr(12'h010, 32'd5);
        wr(12'h000, 32'd1);
        first = -1;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            if (irq_timer_o && first < 0) first = i;
        end
        check("irq_rise_cycle", 64'(first), 64'd5);
        wr(12'h010, 32'hFFFF_FFFF);
        check("irq_still_high", irq_timer_o, 1'b1);
        idle(1);
        check("irq_dropped", irq_timer_o, 1'b0);

        // 64-bit wrap.
        wr(12'h000, 32'd0);
        wr(12'h00C, 32'hFFFF_FFFF);
        wr(12'h008, 32'hFFFF_FFFE);
        wr(12'h000, 32'd1);
        idle(1);
        wr(12'h000, 32'd0);
        rd(12'h008);
        check("wrap_lo", last_rdata, 32'd0);
        rd(12'h00C);
        check("wrap_hi", last_rdata, 32'd0);

        // Write to MTIME_LO in a tick cycle discards that tick.
        wr(12'h000, 32'd1);
        wr(12'h008, 32'h0000_0100);
        wr(12'h000, 32'd0);
        rd(12'h008);
        check("wr_tick_lo", last_rdata, 32'h0000_0101);
        rd(12'h00C);
        check("wr_tick_hi", last_rdata, 32'd0);

        // Random back-to-back traffic.
        for (int n = 0; n < 800; n++) begin
            a   = $urandom();
            idx = int'($urandom_range(0, 9));
            d   = $urandom();
            if (idx == 1) d = $urandom_range(0, 3);
            if ((idx == 4 || idx == 5) && $urandom_range(0, 1) == 1) d = $urandom_range(0, 40);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                  {a[31:12], 10'(idx), a[1:0]}, d);
        end

        // Reset while enabled, irq high and a read response pending.
        wr(12'h004, 32'd0);
        wr(12'h014, 32'd0);
        wr(12'h010, 32'd0);
        wr(12'h000, 32'd1);
        idle(2);
        check("pre_reset_irq", irq_timer_o, 1'b1);
        req_i = 1'b1; we_i = 1'b0; be_i = 4'h0; addr_i = 32'h8; wdata_i = 32'd0;
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_rvalid", rvalid_o, 1'b0);
        check("rst_irq", irq_timer_o, 1'b0);
        req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        rd(12'h000); check("post_rst_ctrl", last_rdata, 32'd0);
        rd(12'h004); check("post_rst_prescale", last_rdata, 32'd0);
        rd(12'h008); check("post_rst_mtime_lo", last_rdata, 32'd0);
        rd(12'h00C); check("post_rst_mtime_hi", last_rdata, 32'd0);
        rd(12'h010); check("post_rst_cmp_lo", last_rdata, 32'hFFFF_FFFF);
        rd(12'h014); check("post_rst_cmp_hi", last_rdata, 32'hFFFF_FFFF);
        check("post_rst_irq", irq_timer_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
